fp_normalize_round: RTL and testbench

Post-arithmetic stage of the FP add/sub datapath. Takes the raw sign, exponent and extended mantissa from the aligned add/sub core and produces the packed IEEE-754 `result`. It normalizes iteratively, one bit per cycle, then rounds to nearest-even. A valid/ready handshake sits on each side, and the output is held until it is consumed.

---
 rtl/fp_pkg.sv | 20 ++
 rtl/fp_rne_round.sv | 20 ++
 rtl/fp_normalize_round.sv | 153 +++++++++++++++
 tb/tb_fp_normalize_round.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP add/sub datapath definitions: field widths, normalizer state encoding
// and the special-value constants used by the core and the post-normalizer.
package fp_pkg;

  localparam int WIDTH     = 32;
  localparam int EXP_BITS  = 8;
  localparam int MANT_BITS = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } norm_state_t;

  localparam logic [WIDTH-1:0]    QNAN         = 32'h7FC0_0000;
  localparam logic [EXP_BITS-1:0] EXP_MAX      = 8'hFF;
  localparam logic [EXP_BITS-1:0] EXP_MIN_NORM = 8'h01;

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even on a {hidden, fraction} mantissa using guard/round/sticky bits.
module fp_rne_round #(
  parameter int MANT_BITS = 23
) (
  input  logic [MANT_BITS:0] mant,
  input  logic               g,
  input  logic               r,
  input  logic               s,
  output logic [MANT_BITS:0] mant_rnd,
  output logic               cout,
  output logic               inexact
);

  logic inc;

  assign inc                = g & (r | s | mant[0]);
  assign {cout, mant_rnd}   = {1'b0, mant} + {{(MANT_BITS+1){1'b0}}, inc};
  assign inexact            = g | r | s;

endmodule

// File: rtl/fp_normalize_round.sv
// Iterative (one bit per cycle) normalizer plus RNE rounder with valid/ready on both sides.
// Define FP_DENORM_EN to deliver tiny results as subnormals instead of flushing them to zero.
module fp_normalize_round
  import fp_pkg::*;
#(
  parameter int WIDTH     = fp_pkg::WIDTH,
  parameter int EXP_BITS  = fp_pkg::EXP_BITS,
  parameter int MANT_BITS = fp_pkg::MANT_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_BITS-1:0]    in_exp,
  input  logic [MANT_BITS+4:0]   in_mant,
  input  logic                   in_nan,
  input  logic                   in_inf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   inexact
);

  localparam int MW = MANT_BITS + 5;
  // One spare exponent bit so a carry out of EXP_MAX is still visible to the overflow test.
  localparam int EW = EXP_BITS + 1;

  localparam logic [WIDTH-1:0] QNAN_W  = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};
  localparam logic [EW-1:0]    EXP_TOP = {1'b0, {EXP_BITS{1'b1}}};
  localparam logic [EW-1:0]    EXP_ONE = {{(EW-1){1'b0}}, 1'b1};

  norm_state_t         state;
  logic                s;
  logic [EW-1:0]       e;
  logic [MW-1:0]       m;
  logic                tiny;

  logic [MANT_BITS:0]   mant_rnd;
  logic                 rnd_cout;
  logic                 rnd_inexact;
  logic [MANT_BITS-1:0] frac_fin;
  logic [EW-1:0]        exp_fin;
  logic                 ovf;

  fp_rne_round #(.MANT_BITS(MANT_BITS)) u_rnd (
    .mant     (m[MW-2:3]),
    .g        (m[2]),
    .r        (m[1]),
    .s        (m[0]),
    .mant_rnd (mant_rnd),
    .cout     (rnd_cout),
    .inexact  (rnd_inexact)
  );

  assign in_ready = (state == IDLE);

  // Rounded result: renormalize on mantissa carry-out; a tiny value rounding into the hidden bit becomes min-normal.
  always_comb begin
    frac_fin = rnd_cout ? mant_rnd[MANT_BITS:1] : mant_rnd[MANT_BITS-1:0];
    exp_fin  = e + {{(EW-1){1'b0}}, rnd_cout};
    if (tiny) exp_fin = mant_rnd[MANT_BITS] ? EXP_ONE : '0;
    ovf      = !tiny && (exp_fin >= EXP_TOP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s         <= in_sign;
            e         <= {1'b0, in_exp};
            m         <= in_mant;
            tiny      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
            if (in_nan) begin
              result <= QNAN_W;
              state  <= DONE;
            end else if (in_inf) begin
              result <= {in_sign, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
              state  <= DONE;
            end else if (in_mant == '0) begin
              result <= {in_sign, {EXP_BITS{1'b0}}, {MANT_BITS{1'b0}}};
              state  <= DONE;
            end else begin
              state  <= NORM;
            end
          end
        end
        NORM: begin
          if (m[MW-1]) begin
            m     <= {1'b0, m[MW-1:2], m[1] | m[0]};
            e     <= e + EXP_ONE;
            state <= ROUND;
          end else if (m[MW-2]) begin
            state <= ROUND;
          end else if (e > EXP_ONE) begin
            m <= {m[MW-2:0], 1'b0};
            e <= e - EXP_ONE;
          end else begin
            tiny  <= 1'b1;
            e     <= '0;
            state <= ROUND;
          end
        end
        ROUND: begin
          if (ovf) begin
            result    <= {s, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
            overflow  <= 1'b1;
            inexact   <= rnd_inexact;
          end else if (tiny) begin
`ifdef FP_DENORM_EN
            result    <= {s, exp_fin[EXP_BITS-1:0], frac_fin};
            underflow <= rnd_inexact;
            inexact   <= rnd_inexact;
`else
            result    <= {s, {EXP_BITS{1'b0}}, {MANT_BITS{1'b0}}};
            underflow <= 1'b1;
            inexact   <= 1'b1;
`endif
          end else begin
            result    <= {s, exp_fin[EXP_BITS-1:0], frac_fin};
            inexact   <= rnd_inexact;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // Special results arrive here straight from IDLE; valid rises one cycle later so they take one cycle.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Scoreboard bench for fp_normalize_round: directed corner cases plus randomized operands.
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        in_nan;
  logic        in_inf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  always #5 clk = ~clk;

  fp_normalize_round dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_nan    (in_nan),
    .in_inf    (in_inf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact)
  );

  typedef struct {
    logic [31:0] res;
    logic        ov;
    logic        un;
    logic        ix;
    int          lat;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string cur_tag  = "reset";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", cur_tag, tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] res, input logic ov, input logic un,
                              input logic ix, input int lat);
    exp_t r;
    r.res = res; r.ov = ov; r.un = un; r.ix = ix; r.lat = lat;
    return r;
  endfunction

  // Reference: normalize with a plain loop, round RNE on the 24-bit significand.
  function automatic exp_t model(input logic sg, input logic [7:0] ex, input logic [27:0] mn,
                                 input logic nan, input logic inf);
    exp_t        r;
    int          e, k;
    bit          tny;
    logic [27:0] mm;
    logic [24:0] q;
    logic        g, rr, st, inc;
    r = mk(32'h0, 1'b0, 1'b0, 1'b0, 1);
    if (nan) begin r.res = 32'h7FC0_0000; return r; end
    if (inf) begin r.res = {sg, 8'hFF, 23'h0}; return r; end
    if (mn == 28'h0) begin r.res = {sg, 31'h0}; return r; end
    e = int'(ex); mm = mn; k = 0; tny = 1'b0;
    if (mm[27]) begin
      mm = {1'b0, mm[27:2], mm[1] | mm[0]};
      e++;
    end else begin
      while (!mm[26] && e > 1) begin mm = mm << 1; e--; k++; end
      if (!mm[26]) begin tny = 1'b1; e = 0; end
    end
    r.lat = k + 2;
    g = mm[2]; rr = mm[1]; st = mm[0];
    r.ix = g | rr | st;
    inc  = g & (rr | st | mm[3]);
    q    = {1'b0, mm[26:3]} + {24'h0, inc};
    if (q[24]) begin q = q >> 1; e++; end
    if (tny && q[23]) e = 1;
    if (!tny && e >= 255) begin
      r.res = {sg, 8'hFF, 23'h0};
      r.ov  = 1'b1;
    end else if (tny) begin
`ifdef FP_DENORM_EN
      r.res = {sg, 8'(e), q[22:0]};
      r.un  = r.ix;
`else
      r.res = {sg, 31'h0};
      r.un  = 1'b1;
      r.ix  = 1'b1;
`endif
    end else begin
      r.res = {sg, 8'(e), q[22:0]};
    end
    return r;
  endfunction

  // Cycles since the most recent accept edge; captured when out_valid first rises.
  int   lat_cnt  = 0;
  int   lat_obs  = 0;
  logic vld_prev = 1'b0;

  always @(posedge clk) begin
    if (in_valid && in_ready) lat_cnt <= 0;
    else                      lat_cnt <= lat_cnt + 1;
  end

  always @(negedge clk) begin
    if (out_valid && !vld_prev) lat_obs = lat_cnt;
    if (out_valid && out_ready && !rst) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 32'(sb.size()), 32'd1);
      end else begin
        exp_t ex;
        ex = sb.pop_front();
        chk("result",    result,    ex.res);
        chk("overflow",  overflow,  ex.ov);
        chk("underflow", underflow, ex.un);
        chk("inexact",   inexact,   ex.ix);
        chk("latency",   32'(lat_obs), 32'(ex.lat));
      end
    end
    vld_prev = out_valid;
  end

  task automatic drive_accept(input logic sg, input logic [7:0] ex, input logic [27:0] mn,
                              input logic nan, input logic inf, input int bp);
    int w;
    @(posedge clk); #1;
    in_valid = 1'b1; in_sign = sg; in_exp = ex; in_mant = mn; in_nan = nan; in_inf = inf;
    out_ready = (bp == 0);
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sign  = 1'($urandom());
    in_exp   = 8'($urandom());
    in_mant  = 28'($urandom());
    in_nan   = 1'($urandom());
    in_inf   = 1'($urandom());
  endtask

  task automatic send(input logic sg, input logic [7:0] ex, input logic [27:0] mn,
                      input logic nan, input logic inf, input exp_t er, input int bp);
    int w;
    sb.push_back(er);
    drive_accept(sg, ex, mn, nan, inf, bp);
    if (bp > 0) begin
      w = 0;
      while (!out_valid && w < 100) begin @(negedge clk); w++; end
      chk("valid_timeout", 32'(out_valid), 32'd1);
      repeat (bp) begin
        @(negedge clk);
        chk("hold_result",   result,   er.res);
        chk("hold_in_ready", in_ready, 32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    w = 0;
    while (sb.size() != 0 && w < 100) begin @(negedge clk); w++; end
    chk("done_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e5;
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
    in_nan = 1'b0; in_inf = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("out_valid", out_valid, 32'd0);
    chk("in_ready",  in_ready,  32'd1);
    chk("result",    result,    32'd0);
    chk("flags",     {overflow, underflow, inexact}, 32'd0);

    cur_tag = "carry_1p5_plus_1p5";
    send(1'b0, 8'd127, 28'hC00_0000, 1'b0, 1'b0, mk(32'h4040_0000, 0, 0, 0, 2), 0);
    cur_tag = "carry_negative";
    send(1'b1, 8'd127, 28'hC00_0000, 1'b0, 1'b0, mk(32'hC040_0000, 0, 0, 0, 2), 1);
    cur_tag = "cancel_3_shifts";
    send(1'b0, 8'd130, 28'h080_0000, 1'b0, 1'b0, mk(32'h3F80_0000, 0, 0, 0, 5), 0);
    cur_tag = "tie_even_mant_ovf";
    send(1'b0, 8'd127, 28'h7FF_FFFC, 1'b0, 1'b0, mk(32'h4000_0000, 0, 0, 1, 2), 0);
    cur_tag = "tie_even_keep";
    send(1'b0, 8'd127, 28'h400_0004, 1'b0, 1'b0, mk(32'h3F80_0000, 0, 0, 1, 2), 0);
    cur_tag = "overflow";
    send(1'b0, 8'd254, 28'h800_0000, 1'b0, 1'b0, mk(32'h7F80_0000, 1, 0, 0, 2), 0);
`ifdef FP_DENORM_EN
    e5 = mk(32'h0040_0000, 0, 0, 0, 2);
`else
    e5 = mk(32'h0000_0000, 0, 1, 1, 2);
`endif
    cur_tag = "tiny";
    send(1'b0, 8'd1, 28'h200_0000, 1'b0, 1'b0, e5, 0);
    cur_tag = "inf_neg";
    send(1'b1, 8'd40, 28'h123_4567, 1'b0, 1'b1, mk(32'hFF80_0000, 0, 0, 0, 1), 0);
    cur_tag = "zero_neg";
    send(1'b1, 8'd90, 28'h000_0000, 1'b0, 1'b0, mk(32'h8000_0000, 0, 0, 0, 1), 0);
    cur_tag = "nan_backpressure";
    send(1'b1, 8'd200, 28'h555_5555, 1'b1, 1'b1, mk(32'h7FC0_0000, 0, 0, 0, 1), 5);

    cur_tag = "rst_mid_norm";
    drive_accept(1'b0, 8'd130, 28'h080_0000, 1'b0, 1'b0, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("out_valid", out_valid, 32'd0);
    chk("in_ready",  in_ready,  32'd1);
    repeat (6) begin
      @(negedge clk);
      chk("no_output", out_valid, 32'd0);
    end
    cur_tag = "after_reset";
    send(1'b0, 8'd130, 28'h080_0000, 1'b0, 1'b0, mk(32'h3F80_0000, 0, 0, 0, 5), 0);

    for (int i = 0; i < 24; i++) begin
      logic        sg;
      logic [7:0]  ex;
      logic [27:0] mn;
      logic [31:0] rv;
      sg = 1'($urandom());
      ex = 8'($urandom_range(254, 1));
      rv = $urandom();
      mn = rv[27:0] >> $urandom_range(26, 0);
      if (mn == 28'h0) mn = 28'h1;
      cur_tag = $sformatf("rand%0d", i);
      send(sg, ex, mn, 1'b0, 1'b0, model(sg, ex, mn, 1'b0, 1'b0), $urandom_range(2, 0));
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
